// File: rtl/smini_sync_pkg.sv
// smini_sync_pkg: shared state encoding, status bit positions and settings-bus address for RX sync sequencing
package smini_sync_pkg;
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_STROBE = 3'd1,
    S_DELAY       = 3'd2,
    S_ARMED       = 3'd3,
    S_PULSE       = 3'd4
  } state_t;
  localparam int FR_RX_SYNC_CTRL = 64;
  localparam logic [6:0] SYNC_ADDR_DEFAULT = 7'(FR_RX_SYNC_CTRL);
  localparam int ST_TIMEOUT = 15;
  localparam int ST_MASTER = 14;
  localparam int ST_SLAVE = 13;
  localparam int ST_STATE_LO = 8;
  localparam int ST_COUNT_LO = 0;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser plus registered rising-edge pulse
//   clock, reset_n (sync, active-low); async_i: asynchronous pin; edge_o: one-clock pulse per rising edge
module sync_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic edge_o
);
  logic [2:0] s_q;
  logic edge_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_q <= '0;
      edge_q <= 1'b0;
    end else begin
      s_q <= {s_q[1:0], async_i};
      edge_q <= s_q[1] & ~s_q[2];
    end
  end
  assign edge_o = edge_q;
endmodule

// File: rtl/rx_sync_sequencer.sv
// rx_sync_sequencer: settings-bus armed master/slave sequencer issuing a strobe-aligned sync_rx pulse
//   clock, reset_n (sync, active-low); serial_*: settings write bus; rx_sample_strobe; rx_slave_sync: async pin
//   sync_rx: RX reset pulse; sync_out/sync_out_oe: pin drive in master mode; busy; status
module rx_sync_sequencer
  import smini_sync_pkg::*;
#(
  parameter logic [6:0] SYNC_ADDR = SYNC_ADDR_DEFAULT,
  parameter int PULSE_LEN = 4,
  parameter int MASTER_DELAY = 3,
  parameter int TIMEOUT_W = 24
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        rx_sample_strobe,
  input  logic        rx_slave_sync,
  output logic        sync_rx,
  output logic        sync_out,
  output logic        sync_out_oe,
  output logic        busy,
  output logic [15:0] status
);
  localparam int DW = MASTER_DELAY > 1 ? $clog2(MASTER_DELAY + 1) : 1;
  localparam logic [3:0] PL_M1 = 4'(PULSE_LEN - 1);
  localparam logic [DW-1:0] MD_M1 = DW'(MASTER_DELAY - 1);
  state_t state_q;
  logic master_q, slave_q, tflag_q, rx_q, out_q;
  logic [TIMEOUT_W-1:0] limit_q, tcnt_q;
  logic [3:0] pcnt_q, ocnt_q;
  logic [DW-1:0] dcnt_q;
  logic [7:0] count_q;
  logic slave_edge, ctrl_wr, arm, go_pulse, unused_bits;
  sync_edge_detect u_pin (
    .clock  (clock),
    .reset_n(reset_n),
    .async_i(rx_slave_sync),
    .edge_o (slave_edge)
  );
  assign ctrl_wr = serial_strobe && serial_addr == SYNC_ADDR;
  assign arm = ctrl_wr && serial_data[2];
  assign unused_bits = ^serial_data;
  // Every route into PULSE shares the same entry actions, applied after the case below.
  assign go_pulse = (state_q == S_WAIT_STROBE && rx_sample_strobe && MASTER_DELAY == 0) ||
                    (state_q == S_DELAY && dcnt_q == '0) ||
                    (state_q == S_ARMED && slave_edge);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      {master_q, slave_q, tflag_q, rx_q, out_q} <= '0;
      limit_q <= '0;
      tcnt_q <= '0;
      pcnt_q <= '0;
      ocnt_q <= '0;
      dcnt_q <= '0;
      count_q <= '0;
    end else begin
      if (ctrl_wr) begin
        master_q <= serial_data[0];
        slave_q <= serial_data[1];
        limit_q <= serial_data[TIMEOUT_W+7:8];
      end
      // sync_out runs on its own counter so it can overlap DELAY/PULSE
      if (out_q) begin
        out_q <= ocnt_q != 4'd0;
        ocnt_q <= ocnt_q - 4'd1;
      end
      case (state_q)
        S_IDLE:
          if (arm && serial_data[0]) state_q <= S_WAIT_STROBE;
          else if (arm && serial_data[1]) begin
            state_q <= S_ARMED;
            tflag_q <= 1'b0;
            tcnt_q <= '0;
          end
        S_WAIT_STROBE:
          if (rx_sample_strobe) begin
            state_q <= S_DELAY;
            dcnt_q <= MD_M1;
            out_q <= 1'b1;
            ocnt_q <= PL_M1;
          end
        S_DELAY: dcnt_q <= dcnt_q - DW'(1);
        S_ARMED:
          if (!slave_edge) begin
            if (limit_q != '0 && tcnt_q == limit_q - TIMEOUT_W'(1)) begin
              state_q <= S_IDLE;
              tflag_q <= 1'b1;
            end else tcnt_q <= tcnt_q + TIMEOUT_W'(1);
          end
        S_PULSE:
          if (pcnt_q == 4'd0) begin
            state_q <= S_IDLE;
            rx_q <= 1'b0;
          end else pcnt_q <= pcnt_q - 4'd1;
        default: state_q <= S_IDLE;
      endcase
      if (go_pulse) begin
        state_q <= S_PULSE;
        rx_q <= 1'b1;
        pcnt_q <= PL_M1;
        count_q <= count_q + 8'd1;
      end
    end
  end
  always_comb begin
    status = '0;
    status[ST_TIMEOUT] = tflag_q;
    status[ST_MASTER] = master_q;
    status[ST_SLAVE] = slave_q;
    status[ST_STATE_LO+:3] = state_q;
    status[ST_COUNT_LO+:8] = count_q;
  end
  assign sync_rx = rx_q;
  assign sync_out = out_q;
  assign sync_out_oe = master_q;
  assign busy = state_q != S_IDLE;
endmodule
